// File: rtl/pool_pkg.sv
// Shared types and helpers for the ReLU + 2x2 max-pool stage.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   DW           - default sample width
//   sample_t     - signed two's-complement sample
//   pool_state_t - frame sequencing states
//   smax()       - signed maximum of two samples
package pool_pkg;

    localparam int DW = 16;

    typedef logic signed [DW-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROW_EVEN = 2'd1,
        ROW_ODD  = 2'd2
    } pool_state_t;

    // Both operands are signed, so '>' is a two's-complement compare.
    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_row_buf.sv
// Row buffer holding horizontal pair maxima of the even row until the odd row pairs with them.
// Latency: write takes effect at the next clock edge; read is combinational.
// Backpressure: none; one write and one read per cycle are always accepted.
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset (clears every entry)
//   wr_en/wr_addr/wr_dat - write port
//   rd_addr/rd_dat   - combinational read port (out-of-range address reads 0)
module pool_row_buf
    import pool_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  sample_t       wr_dat,
    input  logic [AW-1:0] rd_addr,
    output sample_t       rd_dat
);

    sample_t mem [DEPTH];

    // Address decode by compare keeps the address width free of the
    // depth, so callers can pass their full column-counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == AW'(i)) begin
                    mem[i] <= wr_dat;
                end
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_dat = mem[i];
            end
        end
    end

endmodule

// File: rtl/relu_maxpool_2x2.sv
// Optional ReLU then 2x2 stride-2 max-pool over a raster-ordered signed ofmap stream.
// Latency: pool_valid one cycle after the din_valid carrying the window's last sample.
// Backpressure: none; din_valid gaps stall the counters, every pool_valid must be taken.
//
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   start                  - one-cycle pulse, (re)arms for a new frame; a sample in the same cycle is dropped
//   din, din_valid         - signed ofmap sample stream
//   pool_out, pool_valid   - pooled sample and its one-cycle strobe; pool_out holds between strobes
//   busy                   - frame in progress
//   done                   - one-cycle pulse when the last full pair of rows has been consumed
//
// Build option: define RELU_MAXPOOL_RELU_EN to clamp negative inputs to 0
// before any comparison; otherwise raw signed values are pooled.
module relu_maxpool_2x2
    import pool_pkg::*;
#(
    parameter int DW   = pool_pkg::DW,
    parameter int OF_W = 4,
    parameter int OF_H = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic [DW-1:0] pool_out,
    output logic          pool_valid,
    output logic          busy,
    output logic          done
);

    localparam int CW    = (OF_W > 1) ? $clog2(OF_W) : 1;
    localparam int RW    = $clog2(OF_H) + 1;
    localparam int DEPTH = OF_W / 2;

    localparam logic [CW-1:0] COL_LAST  = CW'(OF_W - 1);
    // A trailing odd row can never complete a window, so the frame ends
    // after the last full pair of rows.
    localparam logic [RW-1:0] ROW_LIMIT = RW'(OF_H - (OF_H % 2));

    pool_state_t   state, state_nxt;
    logic [CW-1:0] col_cnt, col_nxt;
    logic [RW-1:0] row_cnt, row_nxt, row_inc;

    sample_t       cur;
    sample_t       prev;
    sample_t       hmax;
    sample_t       buf_rd;
    sample_t       pool_q, pool_nxt;
    logic          pv_q, pv_nxt;
    logic          done_q, done_nxt;
    logic          prev_we;
    logic          buf_we;
    logic [CW-1:0] buf_addr;
    logic          col_odd;
    logic          col_end;

`ifdef RELU_MAXPOOL_RELU_EN
    assign cur = din[DW-1] ? '0 : sample_t'(din);
`else
    assign cur = sample_t'(din);
`endif

    assign hmax     = smax(prev, cur);
    assign buf_addr = col_cnt >> 1;
    assign col_odd  = col_cnt[0];
    assign col_end  = (col_cnt == COL_LAST);
    assign row_inc  = row_cnt + 1'b1;

    pool_row_buf #(
        .DEPTH (DEPTH),
        .AW    (CW)
    ) u_row_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_we),
        .wr_addr (buf_addr),
        .wr_dat  (hmax),
        .rd_addr (buf_addr),
        .rd_dat  (buf_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col_cnt;
        row_nxt   = row_cnt;
        pool_nxt  = pool_q;
        pv_nxt    = 1'b0;
        done_nxt  = 1'b0;
        prev_we   = 1'b0;
        buf_we    = 1'b0;

        // start wins over everything: it aborts any frame in flight and
        // drops a sample arriving in the same cycle.
        if (start) begin
            state_nxt = ROW_EVEN;
            col_nxt   = '0;
            row_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                end

                ROW_EVEN: begin
                    if (din_valid) begin
                        // Even column latches the left sample; odd column
                        // stores the pair maximum for the odd row.
                        prev_we = !col_odd;
                        buf_we  = col_odd;
                        if (col_end) begin
                            state_nxt = ROW_ODD;
                            col_nxt   = '0;
                            row_nxt   = row_inc;
                        end else begin
                            col_nxt = col_cnt + 1'b1;
                        end
                    end
                end

                ROW_ODD: begin
                    if (din_valid) begin
                        prev_we = !col_odd;
                        if (col_odd) begin
                            pool_nxt = smax(hmax, buf_rd);
                            pv_nxt   = 1'b1;
                        end
                        if (col_end) begin
                            col_nxt = '0;
                            row_nxt = row_inc;
                            if (row_inc >= ROW_LIMIT) begin
                                state_nxt = IDLE;
                                done_nxt  = 1'b1;
                            end else begin
                                state_nxt = ROW_EVEN;
                            end
                        end else begin
                            col_nxt = col_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
            prev    <= '0;
            pool_q  <= '0;
            pv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_cnt <= col_nxt;
            row_cnt <= row_nxt;
            pool_q  <= pool_nxt;
            pv_q    <= pv_nxt;
            done_q  <= done_nxt;
            if (prev_we) begin
                prev <= cur;
            end
        end
    end

    assign pool_out   = pool_q;
    assign pool_valid = pv_q;
    assign done       = done_q;
    assign busy       = (state != IDLE);

endmodule

// File: doc/relu_maxpool_2x2.md
Name: relu_maxpool_2x2

Overview:
- Downstream stage of the 3x3 convolution controller.
- Consumes its raster-ordered 16-bit signed ofmap stream (data + valid) and applies optional ReLU followed by 2x2 stride-2 max-pooling.
- Emits one pooled sample per 2x2 window and a one-cycle done pulse per frame.
- Its output feeds the next layer's ifmap stream or writeback.

Parameters:
- DW, 16, data width of the signed two's-complement samples.
- OF_W, 4, ofmap columns per row (≥2).
- OF_H, 4, ofmap rows per frame (≥2).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; arms the block for a new frame
- din  input  DW  ofmap sample from the conv stage (signed)
- din_valid  input  1  din is valid this cycle
- pool_out  output  DW  pooled sample (signed)
- pool_valid  output  1  pool_out is valid this cycle
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (rst_n low, asynchronous): pool_out=0, pool_valid=0, busy=0, done=0, state=IDLE, all counters and row buffer cleared.
- FSM states: IDLE, ROW_EVEN, ROW_ODD.
  - IDLE: din_valid ignored. start -> ROW_EVEN, clears col_cnt/row_cnt, busy=1 next cycle.
  - ROW_EVEN: each accepted sample increments col_cnt. On the odd column (col_cnt[0]=1), hmax = max(prev, cur) is written to row_buf[col_cnt>>1]. At col_cnt=OF_W-1 -> ROW_ODD, col_cnt=0, row_cnt+1.
  - ROW_ODD: same pairing. On the odd column, pool_out <= max(hmax, row_buf[col_cnt>>1]) and pool_valid=1 next cycle. At row end: if row_cnt+1 ≥ (OF_H & ~1) -> IDLE with done=1, busy=0; else -> ROW_EVEN.
- Latency: pool_valid rises exactly 1 cycle after the din_valid cycle carrying the second sample of the window's second row.
- pool_valid and done are single-cycle pulses. pool_out holds its last value otherwise.
- din_valid may deassert for any number of cycles (gaps). Counters advance only on din_valid=1.
- No backpressure: the consumer must accept every pool_valid.
- Comparison is signed over DW bits. No width growth.
- Odd OF_W: the last column of each row is accepted but never paired or stored.
- Odd OF_H: after the last full pair of rows, the block goes to IDLE and pulses done. Samples of the trailing row are ignored in IDLE.
- start while busy: restart immediately. Counters are cleared, no done is emitted for the aborted frame, and any pending partial window is discarded.
- start in the same cycle as din_valid: that sample is dropped. The first sample is accepted the cycle after start.
- done and the final pool_valid assert in the same cycle.
- Reset mid-frame: returns to IDLE per the reset values above. No output is emitted.
- row_buf depth is OF_W/2 entries of DW bits. col_cnt and row_cnt are $clog2(OF_W) and $clog2(OF_H)+1 bits wide.

Optional Feature:
- Macro: RELU_MAXPOOL_RELU_EN.
- Defined: each din is clamped to 0 when negative (MSB=1) before any comparison. pool_out is therefore always ≥0.
- Undefined: pooling operates on raw signed values. Negative results pass through.

Decomposition:
- Package pool_pkg holds:
  - localparam DW=16
  - typedef logic signed [DW-1:0] sample_t
  - typedef enum {IDLE, ROW_EVEN, ROW_ODD} pool_state_t
  - function smax(sample_t a, b)
- Sub-module pool_row_buf: OF_W/2-entry register file with 1 write port and 1 combinational read port, cleared on reset.
- FSM, counters and pairing logic remain in the top module.

Test Plan:
- Basic frame, OF_W=OF_H=4, RELU_EN off, din=1..16 back-to-back after start -> pool_out 6,8,14,16, each pool_valid 1 cycle after samples 6,8,14,16; done with the last output; busy low afterwards.
- Same frame with din negated (-1..-16), RELU_EN on -> four outputs all 0. RELU_EN off -> -1,-3,-9,-11.
- Gapped input, din_valid toggling 1/0 with random gaps, data 1..16 -> identical outputs and ordering to the first scenario; no spurious pool_valid during gaps.
- Restart: start, 7 samples, start again, then 16 samples 100..115 -> no output or done from the aborted frame; outputs 105,107,113,115.
- Odd dims, OF_W=5, OF_H=3, din=1..15 -> two outputs: 7 and 9; done after sample 10; samples 11..15 ignored (no pool_valid).
- Async reset asserted mid-ROW_ODD -> pool_out=0, pool_valid=0, busy=0 immediately. After release with no start, din_valid activity produces no output.
